// File: rtl/raster_pixel_feeder_pkg.sv
// Shared defaults, FSM encodings and the width helper for the raster pixel feeder.
package raster_pixel_feeder_pkg;

  localparam int p_bit_width_in_dflt = 24;
  localparam int p_width_dflt        = 640;
  localparam int p_height_dflt       = 480;
  localparam int p_addr_width_dflt   = 19;
  localparam int p_window_dflt       = 7;
  localparam int p_fifo_depth_dflt   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_t;

  // Bits needed to hold 0..value-1; never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pixel_feeder_fifo.sv
// Show-ahead sync FIFO for read-return data; head on rd_dat, occupancy on count.
// A write is taken when not full or when a read happens in the same cycle; read of empty is ignored.
module pixel_feeder_fifo
  import raster_pixel_feeder_pkg::*;
#(
  parameter int p_depth = 4,
  parameter int p_width = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_vld,
  input  logic [p_width-1:0]          wr_dat,
  input  logic                        rd_rdy,
  output logic [p_width-1:0]          rd_dat,
  output logic [clog2(p_depth+1)-1:0] count
);

  localparam int AW = clog2(p_depth);
  localparam int CW = clog2(p_depth + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(p_depth - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(p_depth);

  logic [p_width-1:0] mem [p_depth];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_wr;
  logic               do_rd;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_rd  = rd_rdy && (count != '0);
  assign do_wr  = wr_vld && ((count != CNT_FULL) || do_rd);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/raster_pixel_feeder.sv
// Streams one frame in raster order from pixel memory to the line buffer with x/y and frame flags.
// Return data to clken is two cycles minimum; sink_en=0 stalls output while fetch runs until credits are gone.
module raster_pixel_feeder
  import raster_pixel_feeder_pkg::*;
#(
  parameter int p_bit_width_in = p_bit_width_in_dflt,
  parameter int p_width        = p_width_dflt,
  parameter int p_height       = p_height_dflt,
  parameter int p_addr_width   = p_addr_width_dflt,
  parameter int p_window       = p_window_dflt,
  parameter int p_fifo_depth   = p_fifo_depth_dflt
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [p_addr_width-1:0]     frame_base,
  output logic                        mem_rd_req,
  output logic [p_addr_width-1:0]     mem_rd_addr,
  input  logic                        mem_rd_ack,
  input  logic                        mem_rd_valid,
  input  logic [p_bit_width_in-1:0]   mem_rd_data,
  input  logic                        sink_en,
  output logic                        clken,
  output logic [p_bit_width_in-1:0]   shiftout,
  output logic [clog2(p_width)-1:0]   pix_x,
  output logic [clog2(p_height)-1:0]  pix_y,
  output logic                        sof,
  output logic                        eol,
  output logic                        eof,
  output logic                        win_valid,
  output logic                        busy
);

  localparam int XW = clog2(p_width);
  localparam int YW = clog2(p_height);
  localparam int NW = clog2(p_width * p_height + 1);
  localparam int CW = clog2(p_fifo_depth + 1);
  localparam int IW = CW + 1;
  localparam logic [NW-1:0] TOTAL  = NW'(p_width * p_height);
  localparam logic [XW-1:0] X_LAST = XW'(p_width - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(p_height - 1);
  localparam logic [IW-1:0] DEPTH  = IW'(p_fifo_depth);

  feeder_state_t             state;
  logic [p_addr_width-1:0]   base;
  logic [NW-1:0]             issued;
  logic [CW-1:0]             outstanding;
  logic [CW-1:0]             fifo_count;
  logic [IW-1:0]             in_use;
  logic [XW-1:0]             cx;
  logic [YW-1:0]             cy;
  logic                      last_sent;
  logic [p_bit_width_in-1:0] head_dat;
  logic                      frame_go;
  logic                      rd_take;
  logic                      rd_accept;
  logic                      pop;

  assign frame_go  = (state == ST_IDLE) && start;
  assign rd_take   = mem_rd_req && mem_rd_ack;
  // Returns with nothing outstanding (stale after reset, or protocol error) never reach the FIFO.
  assign rd_accept = mem_rd_valid && (outstanding != '0);
  assign pop       = sink_en && (fifo_count != '0);
  assign busy      = (state != ST_IDLE);

  // Credits are what remains of the FIFO once queued and in-flight words are reserved.
  assign in_use      = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_rd_req  = (state == ST_FETCH) && (in_use < DEPTH) && (issued < TOTAL);
  assign mem_rd_addr = base + p_addr_width'(issued);

  pixel_feeder_fifo #(
    .p_depth (p_fifo_depth),
    .p_width (p_bit_width_in)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (rd_accept),
    .wr_dat  (mem_rd_data),
    .rd_rdy  (pop),
    .rd_dat  (head_dat),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      base        <= '0;
      issued      <= '0;
      outstanding <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base   <= frame_base;
            issued <= '0;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (rd_take) begin
            issued <= issued + 1'b1;
            if (issued == TOTAL - 1'b1) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((outstanding == '0) && (fifo_count == '0) && last_sent) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (rd_take && !rd_accept)      outstanding <= outstanding + 1'b1;
      else if (!rd_take && rd_accept) outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clken     <= 1'b0;
      shiftout  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      win_valid <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      last_sent <= 1'b0;
    end else begin
      clken <= pop;
      if (pop) begin
        shiftout  <= head_dat;
        pix_x     <= cx;
        pix_y     <= cy;
        sof       <= (cx == '0) && (cy == '0);
        eol       <= (cx == X_LAST);
        eof       <= (cx == X_LAST) && (cy == Y_LAST);
        win_valid <= (int'(cx) >= p_window - 1) && (int'(cy) >= p_window - 1);
      end

      if (frame_go) begin
        cx        <= '0;
        cy        <= '0;
        last_sent <= 1'b0;
      end else if (pop) begin
        if (cx == X_LAST) begin
          cx <= '0;
          if (cy == Y_LAST) begin
            cy        <= '0;
            last_sent <= 1'b1;
          end else begin
            cy <= cy + 1'b1;
          end
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

  // Idle is excluded: returns for reads issued before a reset may still trickle in.
  assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_rd_valid && (outstanding == '0) && (state != ST_IDLE)));

endmodule

// File: tb/tb_raster_pixel_feeder.sv
// Directed bench: raster order and flags, memory latency, sink stalls, mid-frame reset, 7x7 boundary.
module tb_raster_pixel_feeder;
  import raster_pixel_feeder_pkg::*;

  localparam int W = 10, H = 8, D = 4, K = 7, AW = 19, BW = 24;
  localparam int XW = clog2(W), YW = clog2(H);
  localparam int W2 = 7, H2 = 7, XW2 = clog2(W2), YW2 = clog2(H2);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_ack = 1'b1;
  logic          mem_rd_valid;
  logic [BW-1:0] mem_rd_data;
  logic          sink_en = 1'b1;
  logic          clken, sof, eol, eof, win_valid, busy;
  logic [BW-1:0] shiftout;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;

  raster_pixel_feeder #(
    .p_bit_width_in(BW), .p_width(W), .p_height(H),
    .p_addr_width(AW), .p_window(K), .p_fifo_depth(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_base(frame_base),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .sink_en(sink_en),
    .clken(clken), .shiftout(shiftout), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eol(eol), .eof(eof), .win_valid(win_valid), .busy(busy)
  );

  // 7x7 instance with a fixed zero-wait memory
  logic           start2 = 1'b0;
  logic [AW-1:0]  base2 = '0;
  logic           req2, ack2 = 1'b1, v2 = 1'b0, sink2 = 1'b1;
  logic [AW-1:0]  addr2;
  logic [BW-1:0]  d2;
  logic           clken2, sof2, eol2, eof2, win2, busy2;
  logic [BW-1:0]  shiftout2;
  logic [XW2-1:0] pix_x2;
  logic [YW2-1:0] pix_y2;

  raster_pixel_feeder #(
    .p_bit_width_in(BW), .p_width(W2), .p_height(H2),
    .p_addr_width(AW), .p_window(K), .p_fifo_depth(D)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .frame_base(base2),
    .mem_rd_req(req2), .mem_rd_addr(addr2), .mem_rd_ack(ack2),
    .mem_rd_valid(v2), .mem_rd_data(d2), .sink_en(sink2),
    .clken(clken2), .shiftout(shiftout2), .pix_x(pix_x2), .pix_y(pix_y2),
    .sof(sof2), .eol(eol2), .eof(eof2), .win_valid(win2), .busy(busy2)
  );

  always @(posedge clk) begin
    v2 <= req2 && ack2;
    d2 <= BW'(addr2);
  end

  // Memory model for the main instance: in-order, fixed latency, data equals address
  int            lat = 1;
  bit            rnd_ack = 1'b0;
  int            sink_mode = 0;
  logic [7:0]    pipe_v = '0;
  logic [BW-1:0] pipe_d [8];

  assign mem_rd_valid = pipe_v[0];
  assign mem_rd_data  = pipe_d[0];

  always @(posedge clk) begin
    for (int i = 0; i < 7; i++) begin
      pipe_v[i] <= pipe_v[i+1];
      pipe_d[i] <= pipe_d[i+1];
    end
    pipe_v[7] <= 1'b0;
    if (mem_rd_req && mem_rd_ack) begin
      pipe_v[lat-1] <= 1'b1;
      pipe_d[lat-1] <= BW'(mem_rd_addr);
    end
  end

  // Bus observers: outstanding count, req/addr stability, accepted requests, start-to-pixel timing
  int            cyc = 0, st_cyc = 0, outs = 0, max_out = 0, stab_err = 0, acks = 0;
  logic          prev_wait = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start && !busy && reset_n) st_cyc <= cyc + 1;
    if (!reset_n) begin
      outs      <= 0;
      prev_wait <= 1'b0;
    end else begin
      outs <= outs + int'(mem_rd_req && mem_rd_ack) - int'(mem_rd_valid && (outs > 0));
      if (outs > max_out) max_out <= outs;
      if (prev_wait && (!mem_rd_req || (mem_rd_addr != prev_addr))) stab_err <= stab_err + 1;
      prev_wait <= mem_rd_req && !mem_rd_ack;
      prev_addr <= mem_rd_addr;
      if (mem_rd_req && mem_rd_ack) acks <= acks + 1;
    end
  end

  // Pixel monitor: expected raster sequence from base + index
  int pix_n = 0, seq_err = 0, sof_n = 0, eol_n = 0, eof_n = 0, win_n = 0;
  int first_lat = -1, run_pix0 = 0, exp_base = 0;

  always @(negedge clk) begin
    if (clken) begin
      int idx;
      idx = pix_n - run_pix0;
      if (idx == 0) first_lat = cyc - st_cyc;
      if ((shiftout !== BW'(exp_base + idx)) || (pix_x !== XW'(idx % W)) ||
          (pix_y !== YW'(idx / W)) || (sof !== (idx == 0)) ||
          (eol !== ((idx % W) == W - 1)) || (eof !== (idx == W * H - 1)) ||
          (win_valid !== (((idx % W) >= K - 1) && ((idx / W) >= K - 1))))
        seq_err = seq_err + 1;
      sof_n = sof_n + int'(sof);
      eol_n = eol_n + int'(eol);
      eof_n = eof_n + int'(eof);
      win_n = win_n + int'(win_valid);
      pix_n = pix_n + 1;
    end
  end

  int n2 = 0, win2_n = 0, win2_x = -1, win2_y = -1, win2_eof = 0;
  always @(negedge clk) begin
    if (clken2) begin
      n2 = n2 + 1;
      if (win2) begin
        win2_n   = win2_n + 1;
        win2_x   = int'(pix_x2);
        win2_y   = int'(pix_y2);
        win2_eof = int'(eof2);
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int rcyc = 0, pulse_at = -1;

  task automatic tick();
    @(negedge clk);
    rcyc++;
    mem_rd_ack = rnd_ack ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (sink_mode == 0) sink_en = 1'b1;
    else sink_en = !((rcyc >= 30) && (rcyc < 50)) && (((rcyc / 3) % 2) == 0);
    if (rcyc == pulse_at) begin
      start      = 1'b1;
      frame_base = AW'('h3000);
    end else begin
      start = 1'b0;
    end
  endtask

  task automatic run_frame(input string tag, input int base, input int latency, input bit rnd,
                           input int smode, input int pulse, input int abort_at);
    int p0, s0, sf0, el0, ef0, w0, a0, guard, stale, seen;
    lat = latency; rnd_ack = rnd; sink_mode = smode; pulse_at = pulse;
    p0 = pix_n; s0 = seq_err; sf0 = sof_n; el0 = eol_n; ef0 = eof_n; w0 = win_n; a0 = acks;
    run_pix0 = pix_n; exp_base = base; rcyc = 0;
    @(negedge clk);
    frame_base = AW'(base);
    start      = 1'b1;
    mem_rd_ack = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    sink_en    = 1'b1;
    tick();
    check_eq({tag, " busy after start"}, busy, 1);
    check_eq({tag, " first addr"}, mem_rd_addr, base);
    guard = 0;
    while (busy && (guard < 3000)) begin
      tick();
      guard++;
      if ((smode == 1) && (rcyc == 49)) begin
        check_eq({tag, " req low at zero credit"}, mem_rd_req, 0);
        check_eq({tag, " words held in stall"}, (acks - a0) - (pix_n - p0), D);
      end
      if ((abort_at > 0) && ((pix_n - p0) >= abort_at) && (outs > int'(mem_rd_valid))) begin
        #2 reset_n = 1'b0;
        #1;
        check_eq({tag, " clken in reset"}, clken, 0);
        check_eq({tag, " busy in reset"}, busy, 0);
        check_eq({tag, " req in reset"}, mem_rd_req, 0);
        check_eq({tag, " shiftout in reset"}, shiftout, 0);
        stale = 0; seen = 0;
        for (int i = 0; i < 12; i++) begin
          tick();
          if (i == 1) reset_n = 1'b1;
          stale = stale + int'(mem_rd_valid);
          seen  = seen + int'(clken);
        end
        check_eq({tag, " stale returns seen"}, stale > 0, 1);
        check_eq({tag, " no pixel after reset"}, seen, 0);
        check_eq({tag, " idle after reset"}, busy, 0);
        break;
      end
    end
    start = 1'b0;
    if (abort_at == 0) begin
      check_eq({tag, " finished in time"}, guard < 3000, 1);
      check_eq({tag, " pixel count"}, pix_n - p0, W * H);
      check_eq({tag, " sequence errors"}, seq_err - s0, 0);
      check_eq({tag, " sof count"}, sof_n - sf0, 1);
      check_eq({tag, " eol count"}, eol_n - el0, H);
      check_eq({tag, " eof count"}, eof_n - ef0, 1);
      check_eq({tag, " win_valid count"}, win_n - w0, 8);
      if ((latency == 1) && (smode == 0)) check_eq({tag, " first clken latency"}, first_lat, 3);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    check_eq("reset clken", clken, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset req", mem_rd_req, 0);
    check_eq("reset shiftout", shiftout, 0);
    check_eq("reset flags", {sof, eol, eof, win_valid}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("zero-wait", 0, 1, 1'b0, 0, 20, 0);
    run_frame("lat5", 0, 5, 1'b1, 0, -1, 0);
    check_eq("max outstanding within depth", max_out <= D, 1);
    run_frame("sink toggle", 'h80, 1, 1'b0, 1, -1, 0);
    run_frame("abort", 'h40, 5, 1'b1, 0, -1, 37);
    run_frame("after reset", 'h200, 1, 1'b0, 0, -1, 0);
    run_frame("base 0x100", 'h100, 1, 1'b0, 0, -1, 0);
    check_eq("req/addr held until ack", stab_err, 0);
    check_eq("max outstanding overall", max_out <= D, 1);

    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    guard = 0;
    while (busy2 && (guard < 500)) begin
      @(negedge clk);
      guard++;
    end
    check_eq("7x7 finished in time", guard < 500, 1);
    check_eq("7x7 pixel count", n2, W2 * H2);
    check_eq("7x7 win_valid count", win2_n, 1);
    check_eq("7x7 win_valid x", win2_x, 6);
    check_eq("7x7 win_valid y", win2_y, 6);
    check_eq("7x7 win_valid with eof", win2_eof, 1);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
